key_led_pio: RTL and testbench

Parametrised Avalon-MM peripheral for pushbutton inputs and LED outputs in the Nios II system, superseding plain key/LED PIO exports. Per-key synchronisation and debounce, sticky edge capture with a configurable edge mode, a maskable level interrupt, and an LED register with hardware blink. Sits on the system interconnect as a slave; `key_export`/`led_export` go to board pins.

---
 rtl/key_led_pio_pkg.sv | 20 ++
 rtl/key_led_pio_if.sv | 21 ++
 rtl/key_led_pio_key_debounce.sv | 49 ++++
 rtl/key_led_pio.sv | 135 +++++++++++++
 tb/tb_key_led_pio.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/key_led_pio_pkg.sv
// Shared constants for the key/LED peripheral: register map, edge-capture
// modes and bus widths.
package key_led_pio_pkg;

    localparam int ADDR_W         = 3;
    localparam int DATA_W         = 32;
    localparam int BLINK_PERIOD_W = 24;

    localparam logic [ADDR_W-1:0] ADDR_KEY          = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_EDGE         = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK     = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_LED          = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_BLINK_MASK   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_BLINK_PERIOD = 3'd5;

    localparam int EDGE_PRESS   = 0;
    localparam int EDGE_RELEASE = 1;
    localparam int EDGE_BOTH    = 2;

endpackage

// File: rtl/key_led_pio_if.sv
// Avalon-MM slave bus bundle for key_led_pio (fixed read latency 1).
interface key_led_pio_if;
    import key_led_pio_pkg::*;

    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [DATA_W-1:0] avs_writedata;
    logic [DATA_W-1:0] avs_readdata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata
    );

endinterface

// File: rtl/key_led_pio_key_debounce.sv
// One key: 2-flop synchroniser, stability counter and debounced state.
// key_rise/key_fall pulse in the cycle the new state is accepted.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic key_raw,
    output logic key_state,
    output logic key_rise,
    output logic key_fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             state_q;
    logic             synced;
    logic             accept;

    // Pins are active-low; the synchroniser idles at 1 so reset looks "released".
    assign synced = ~sync_q[1];
    assign accept = (synced != state_q) && (cnt_q == CNT_MAX);

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            state_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], key_raw};
            if (synced == state_q) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q   <= '0;
                state_q <= synced;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign key_state = state_q;
    assign key_rise  = accept & synced;
    assign key_fall  = accept & ~synced;

endmodule

// File: rtl/key_led_pio.sv
// Avalon-MM key/LED peripheral: debounced keys, sticky edge capture with
// maskable irq, and an LED register with hardware blink.
module key_led_pio
    import key_led_pio_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int N_LEDS          = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_MODE       = 0
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    key_led_pio_if.slave      avs,
    input  logic [N_KEYS-1:0] key_export,
    output logic [N_LEDS-1:0] led_export,
    output logic              irq
);

    logic [N_KEYS-1:0] key_state;
    logic [N_KEYS-1:0] key_rise;
    logic [N_KEYS-1:0] key_fall;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_clk      (clk_clk),
            .reset_reset_n(reset_reset_n),
            .key_raw      (key_export[k]),
            .key_state    (key_state[k]),
            .key_rise     (key_rise[k]),
            .key_fall     (key_fall[k])
        );
    end

    logic [N_KEYS-1:0]         edge_q;
    logic [N_KEYS-1:0]         irq_mask_q;
    logic [N_LEDS-1:0]         led_q;
    logic [N_LEDS-1:0]         blink_mask_q;
    logic [BLINK_PERIOD_W-1:0] period_q;
    logic [BLINK_PERIOD_W-1:0] presc_q;
    logic                      phase_q;

    logic wr_edge, wr_irq_mask, wr_led, wr_blink_mask, wr_period;

    assign wr_edge       = avs.avs_write && (avs.avs_address == ADDR_EDGE);
    assign wr_irq_mask   = avs.avs_write && (avs.avs_address == ADDR_IRQ_MASK);
    assign wr_led        = avs.avs_write && (avs.avs_address == ADDR_LED);
    assign wr_blink_mask = avs.avs_write && (avs.avs_address == ADDR_BLINK_MASK);
    assign wr_period     = avs.avs_write && (avs.avs_address == ADDR_BLINK_PERIOD);

    logic wdata_unused;
    assign wdata_unused = ^avs.avs_writedata;

    logic [N_KEYS-1:0] edge_set;
    logic [N_KEYS-1:0] edge_clr;
    logic [N_KEYS-1:0] edge_next;

    always_comb begin
        edge_set = '0;
        case (EDGE_MODE)
            EDGE_PRESS:   edge_set = key_rise;
            EDGE_RELEASE: edge_set = key_fall;
            default:      edge_set = key_rise | key_fall;
        endcase
    end

    // A capture in the same cycle as its W1C survives: set is OR'd in last.
    assign edge_clr  = wr_edge ? avs.avs_writedata[N_KEYS-1:0] : '0;
    assign edge_next = (edge_q & ~edge_clr) | edge_set;

    logic [DATA_W-1:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (avs.avs_address)
            ADDR_KEY:          rd_mux = DATA_W'(key_state);
            ADDR_EDGE:         rd_mux = DATA_W'(edge_q);
            ADDR_IRQ_MASK:     rd_mux = DATA_W'(irq_mask_q);
            ADDR_LED:          rd_mux = DATA_W'(led_q);
            ADDR_BLINK_MASK:   rd_mux = DATA_W'(blink_mask_q);
            ADDR_BLINK_PERIOD: rd_mux = DATA_W'(period_q);
            default:           rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            avs.avs_readdata <= '0;
            edge_q           <= '0;
            irq_mask_q       <= '0;
            led_q            <= '0;
            blink_mask_q     <= '0;
            period_q         <= '0;
            irq              <= 1'b0;
            led_export       <= '0;
        end else begin
            if (avs.avs_read) begin
                avs.avs_readdata <= rd_mux;
            end
            edge_q <= edge_next;
            irq    <= |(edge_q & irq_mask_q);
            if (wr_irq_mask) begin
                irq_mask_q <= avs.avs_writedata[N_KEYS-1:0];
            end
            if (wr_led) begin
                led_q <= avs.avs_writedata[N_LEDS-1:0];
            end
            if (wr_blink_mask) begin
                blink_mask_q <= avs.avs_writedata[N_LEDS-1:0];
            end
            if (wr_period) begin
                period_q <= avs.avs_writedata[BLINK_PERIOD_W-1:0];
            end
            led_export <= led_q ^ (blink_mask_q & {N_LEDS{phase_q}});
        end
    end

    // A period write restarts the blink cycle from the dark phase.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            presc_q <= '0;
            phase_q <= 1'b0;
        end else if (wr_period || (period_q == '0)) begin
            presc_q <= '0;
            phase_q <= 1'b0;
        end else if (presc_q >= period_q - BLINK_PERIOD_W'(1)) begin
            presc_q <= '0;
            phase_q <= ~phase_q;
        end else begin
            presc_q <= presc_q + BLINK_PERIOD_W'(1);
        end
    end

endmodule

// File: tb/tb_key_led_pio.sv
// Directed bench for key_led_pio; bus reads are checked by a scoreboard
// monitor, pin outputs by direct compares.
module tb_key_led_pio;
    import key_led_pio_pkg::*;

    localparam int NK = 4;
    localparam int NL = 10;
    localparam int DB = 16;

    logic          clk_clk = 1'b0;
    logic          reset_reset_n;
    logic [NK-1:0] key_export;
    logic [NL-1:0] led_export;
    logic          irq;

    key_led_pio_if bus ();

    key_led_pio #(
        .N_KEYS         (NK),
        .N_LEDS         (NL),
        .DEBOUNCE_CYCLES(DB),
        .EDGE_MODE      (0)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .avs          (bus),
        .key_export   (key_export),
        .led_export   (led_export),
        .irq          (irq)
    );

    always #5 clk_clk = ~clk_clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic        rd_seen = 1'b0;
    logic [31:0] mon_exp;
    string       mon_tag;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk_clk) rd_seen <= bus.avs_read & reset_reset_n;

    always @(negedge clk_clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: got 0x%0h expected no read", bus.avs_readdata);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_tag = tag_q.pop_front();
                check(mon_tag, bus.avs_readdata, mon_exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic bus_set(logic rd, logic wr, logic [2:0] a, logic [31:0] d);
        bus.avs_read      = rd;
        bus.avs_write     = wr;
        bus.avs_address   = a;
        bus.avs_writedata = d;
    endtask

    task automatic expect_rd(logic [31:0] e, string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic rd(logic [2:0] a, logic [31:0] e, string t);
        bus_set(1'b1, 1'b0, a, 32'h0);
        expect_rd(e, t);
        tick();
        bus_set(1'b0, 1'b0, 3'd0, 32'h0);
    endtask

    task automatic wr(logic [2:0] a, logic [31:0] d);
        bus_set(1'b0, 1'b1, a, d);
        tick();
        bus_set(1'b0, 1'b0, 3'd0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_reset_n = 1'b0;
        key_export    = '1;
        bus_set(1'b0, 1'b0, 3'd0, 32'h0);
        repeat (3) tick();
        check("rst_led", 32'(led_export), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_rdata", bus.avs_readdata, 32'h0);
        reset_reset_n = 1'b1;
        tick();

        for (int a = 0; a < 8; a++) rd(3'(a), 32'h0, $sformatf("reset_rd%0d", a));

        // key 1 press: KEY/EDGE at edge 18 after the pin change, irq one later
        wr(ADDR_IRQ_MASK, 32'h2);
        for (int i = 1; i <= 22; i++) begin
            key_export[1] = 1'b0;
            bus_set(1'b1, 1'b0, ADDR_KEY, 32'h0);
            expect_rd((i >= 19) ? 32'h2 : 32'h0, $sformatf("key1_press_c%0d", i));
            tick();
            check($sformatf("irq_press_c%0d", i), 32'(irq), (i >= 19) ? 32'h1 : 32'h0);
        end
        bus_set(1'b0, 1'b0, 3'd0, 32'h0);
        rd(ADDR_EDGE, 32'h2, "edge_press");

        // key 0 bounce: low 10, high 3, then low for good from cycle 14
        for (int i = 1; i <= 36; i++) begin
            key_export[0] = (i >= 11 && i <= 13);
            bus_set(1'b1, 1'b0, ADDR_KEY, 32'h0);
            expect_rd((i >= 32) ? 32'h3 : 32'h2, $sformatf("key0_bounce_c%0d", i));
            tick();
        end
        bus_set(1'b0, 1'b0, 3'd0, 32'h0);
        rd(ADDR_EDGE, 32'h3, "edge_bounce");
        wr(ADDR_EDGE, 32'h1);
        rd(ADDR_EDGE, 32'h2, "edge_w1c_key0");
        check("irq_key0_masked", 32'(irq), 32'h1);

        // release of key 1 is not captured in press mode
        key_export[1] = 1'b1;
        repeat (22) tick();
        rd(ADDR_KEY, 32'h1, "key1_release");
        rd(ADDR_EDGE, 32'h2, "edge_release_ignored");

        // re-press key 1 with a W1C landing on the accept edge
        for (int i = 1; i <= 20; i++) begin
            key_export[1] = 1'b0;
            if (i == 18) bus_set(1'b0, 1'b1, ADDR_EDGE, 32'h2);
            else bus_set(1'b0, 1'b0, 3'd0, 32'h0);
            tick();
            check($sformatf("irq_setwins_c%0d", i), 32'(irq), 32'h1);
        end
        bus_set(1'b0, 1'b0, 3'd0, 32'h0);
        rd(ADDR_EDGE, 32'h2, "edge_setwins");
        rd(ADDR_KEY, 32'h3, "key_both");
        wr(ADDR_EDGE, 32'h2);
        check("irq_w1c_lag", 32'(irq), 32'h1);
        tick();
        check("irq_w1c", 32'(irq), 32'h0);
        rd(ADDR_EDGE, 32'h0, "edge_cleared");

        // read and write of LED together return the old value
        bus_set(1'b1, 1'b1, ADDR_LED, 32'h0F0);
        expect_rd(32'h0, "rdwr_same_addr");
        tick();
        bus_set(1'b0, 1'b0, 3'd0, 32'h0);
        rd(ADDR_LED, 32'h0F0, "led_reg");
        wr(ADDR_BLINK_MASK, 32'h300);
        tick();
        check("led_noblink", 32'(led_export), 32'h0F0);

        wr(ADDR_BLINK_PERIOD, 32'h4);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("blink_c%0d", k), 32'(led_export),
                  (((k - 1) / 4) % 2 == 1) ? 32'h3F0 : 32'h0F0);
        end
        wr(ADDR_BLINK_PERIOD, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("blink_off_c%0d", k), 32'(led_export), 32'h0F0);
        end
        rd(ADDR_BLINK_MASK, 32'h300, "bmask_rd");

        // reset mid-debounce of key 2 while blinking
        wr(ADDR_BLINK_PERIOD, 32'h4);
        wr(ADDR_IRQ_MASK, 32'hF);
        rd(ADDR_LED, 32'h0F0, "led_pre_reset");
        for (int i = 1; i <= 12; i++) begin
            key_export[2] = 1'b0;
            tick();
        end
        reset_reset_n = 1'b0;
        key_export    = '1;
        tick();
        check("mid_rst_led", 32'(led_export), 32'h0);
        check("mid_rst_irq", 32'(irq), 32'h0);
        check("mid_rst_rdata", bus.avs_readdata, 32'h0);
        reset_reset_n = 1'b1;
        repeat (25) tick();
        check("post_rst_led", 32'(led_export), 32'h0);
        check("post_rst_irq", 32'(irq), 32'h0);
        for (int a = 0; a < 8; a++) rd(3'(a), 32'h0, $sformatf("post_rst_rd%0d", a));

        repeat (2) tick();
        check("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
